// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath: array size, default result width and
// the drain FSM state encoding.
package systolic_pkg;

  localparam int unsigned N                 = 4;
  localparam int unsigned AccumulateDefault = 32;

  typedef logic [1:0] drain_state_t;

  localparam drain_state_t StIdle    = 2'd0;
  localparam drain_state_t StWait    = 2'd1;
  localparam drain_state_t StCapture = 2'd2;
  localparam drain_state_t StDone    = 2'd3;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty flags and a head that reads 0 when empty.
module result_fifo #(
  parameter int unsigned Width = 128,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                 (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign rdata = empty ? '0 : mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/systolic_drain.sv
// South-edge collector: deskews the staggered column outputs of the 4x4 array into whole
// vectors, buffers them and streams them out over valid/ready.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int unsigned ACCUMULATE = AccumulateDefault,
  parameter int unsigned LAT        = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [CNT_W-1:0]               num_vectors,
  input  logic [N-1:0][ACCUMULATE-1:0]   result_buffer,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N-1:0][ACCUMULATE-1:0]   out_data,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int unsigned WaitW = $clog2(LAT + 3);

  logic [2:0][ACCUMULATE-1:0] col0_q;
  logic [1:0][ACCUMULATE-1:0] col1_q;
  logic [ACCUMULATE-1:0]      col2_q;
  logic [N-1:0][ACCUMULATE-1:0] aligned;

  drain_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, fifo_full, fifo_empty;
  logic [N*ACCUMULATE-1:0] fifo_rdata;

  // Free-running deskew: column c is delayed 3-c cycles so all columns meet together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col0_q <= '0;
      col1_q <= '0;
      col2_q <= '0;
    end else begin
      col0_q <= {col0_q[1:0], result_buffer[0]};
      col1_q <= {col1_q[0], result_buffer[1]};
      col2_q <= result_buffer[2];
    end
  end

  assign aligned[0] = col0_q[2];
  assign aligned[1] = col1_q[1];
  assign aligned[2] = col2_q;
  assign aligned[3] = result_buffer[3];

  assign pop = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (num_vectors == '0) begin
            state_d = StDone;
          end else begin
            state_d    = StWait;
            cnt_d      = num_vectors;
            wait_d     = '0;
            overflow_d = 1'b0;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (wait_q == WaitW'(LAT + 1)) state_d = StCapture;
        else                           wait_d  = wait_q + 1'b1;
      end
      StCapture: begin
        push  = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    // The array cannot stall, so a vector that finds no room is lost and flagged.
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wait_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      overflow_q <= overflow_d;
    end
  end

  result_fifo #(
    .Width (N * ACCUMULATE),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (aligned),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata;
  assign busy      = (state_q == StWait) || (state_q == StCapture);
  assign done      = (state_q == StDone);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: drives skewed column data per run and checks deskewed
// vectors against a scoreboard, plus cycle-exact busy/done/valid/overflow behaviour.
module tb_systolic_drain;

  localparam int LAT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        num_vectors;
  logic [3:0][31:0]  rb;
  logic              out_valid;
  logic              out_ready;
  logic [3:0][31:0]  out_data;
  logic              busy, done, overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run_n = 0;
  int pop_count = 0;
  logic rdy_cfg = 1'b0;
  logic [31:0]  vec_val [0:15][0:3];
  logic [127:0] sb [$];

  systolic_drain #(
    .ACCUMULATE (32),
    .LAT        (LAT),
    .DEPTH      (4),
    .CNT_W      (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_vectors   (num_vectors),
    .result_buffer (rb),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Column c of vector k is presented in cycle k+c+LAT; everything else is junk.
  task automatic drive_rb();
    for (int c = 0; c < 4; c++) begin
      int k;
      k = cyc - LAT - c;
      if (k >= 0 && k < run_n) rb[c] = vec_val[k][c];
      else                     rb[c] = $urandom;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    out_ready = rdy_cfg;
    drive_rb();
    @(negedge clk);
  endtask

  // base < 0 selects the 10,20,30,40 single-vector pattern; otherwise base+100k+c.
  task automatic start_run(input int n, input int kept, input int base);
    @(posedge clk);
    #1;
    cyc = 0;
    for (int k = 0; k < n; k++)
      for (int c = 0; c < 4; c++)
        vec_val[k][c] = (base < 0) ? 32'(10 * (c + 1)) : 32'(base + 100 * k + c);
    for (int k = 0; k < kept; k++)
      sb.push_back({vec_val[k][3], vec_val[k][2], vec_val[k][1], vec_val[k][0]});
    run_n = n;
    start = 1'b1;
    num_vectors = 8'(n);
    out_ready = rdy_cfg;
    drive_rb();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic single_run(input string pfx);
    start_run(1, 1, -1);
    for (int i = 1; i <= 12; i++) begin
      next_cycle();
      chk1({pfx, "_busy"},  busy,      cyc >= 1 && cyc <= 7);
      chk1({pfx, "_done"},  done,      cyc == 8);
      chk1({pfx, "_valid"}, out_valid, cyc == 8);
    end
  endtask

  // Scoreboard side: every accepted vector must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      logic [127:0] exp;
      exp = (sb.size() > 0) ? sb.pop_front() : {4{32'hdeadbeef}};
      chkw("pop_data", out_data, exp);
      pop_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    reset = 1'b0;
    start = 1'b0;
    num_vectors = '0;
    out_ready = 1'b0;
    rb = '0;
    #2;
    chk1("rst_valid", out_valid, 1'b0);
    chkw("rst_data", out_data, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ovf", overflow, 1'b0);
    #10 reset = 1'b1;

    // Single vector
    rdy_cfg = 1'b1;
    single_run("single");
    chkw("single_sb_empty", 128'(sb.size()), '0);

    // Streaming, back-to-back output
    start_run(4, 4, 0);
    for (int i = 1; i <= 14; i++) begin
      next_cycle();
      chk1("stream_valid", out_valid, cyc >= 8 && cyc <= 11);
      chk1("stream_done", done, cyc == 11);
    end
    chk1("stream_ovf", overflow, 1'b0);
    chkw("stream_sb_empty", 128'(sb.size()), '0);

    // Overflow with a stalled sink, then drain
    rdy_cfg = 1'b0;
    idle(2);
    start_run(6, 4, 5000);
    for (int i = 1; i <= 14; i++) begin
      next_cycle();
      chk1("ovf_flag", overflow, cyc >= 12);
      chk1("ovf_done", done, cyc == 13);
      chk1("ovf_busy", busy, cyc >= 1 && cyc <= 12);
    end
    pops0 = pop_count;
    rdy_cfg = 1'b1;
    idle(7);
    chkw("ovf_pops", 128'(pop_count - pops0), 128'(4));
    chk1("ovf_drained", out_valid, 1'b0);
    chkw("ovf_sb_empty", 128'(sb.size()), '0);

    // Zero count
    start_run(0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      chk1("zero_done", done, cyc == 1);
      chk1("zero_busy", busy, 1'b0);
      chk1("zero_valid", out_valid, 1'b0);
    end

    // Start during WAIT is ignored
    pops0 = pop_count;
    start_run(2, 2, 7000);
    for (int i = 1; i <= 12; i++) begin
      next_cycle();
      if (cyc == 3) begin
        start = 1'b1;
        num_vectors = 8'd9;
      end
      chk1("ign_done", done, cyc == 9);
      if (cyc == 1) chk1("ign_ovf_cleared", overflow, 1'b0);
    end
    idle(4);
    chkw("ign_pops", 128'(pop_count - pops0), 128'(2));
    chk1("ign_idle_valid", out_valid, 1'b0);

    // Asynchronous reset with two vectors buffered
    rdy_cfg = 1'b0;
    idle(1);
    start_run(4, 0, 9000);
    for (int i = 1; i <= 9; i++) next_cycle();
    chk1("prerst_valid", out_valid, 1'b1);
    chk1("prerst_busy", busy, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk1("midrst_valid", out_valid, 1'b0);
    chkw("midrst_data", out_data, '0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_ovf", overflow, 1'b0);
    #1 reset = 1'b1;
    rdy_cfg = 1'b1;
    single_run("postrst");
    chkw("final_sb_empty", 128'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
